// File: rtl/sfx_request_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sfx_request_queue : edge-triggered fire/hit sound requests queued in a small
// FIFO and paced to a downstream player. Optional macro: SFX_COALESCE_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sfx_request_queue #(
  parameter int DEPTH       = 4,
  parameter int GAP_CYCLES  = 100_000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fire_req,
  input  logic                   hit_req,
  input  logic                   busy,
  input  logic                   clr_ovf,
  output logic                   play,
  output logic [1:0]             code,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [1:0]    CODE_FIRE = 2'b01;
  localparam logic [1:0]    CODE_HIT  = 2'b10;

  generate
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sfx_request_queue: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ACK   = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          play_q, play_d;
  logic [1:0]    code_q, code_d;
  logic          ovf_q, ovf_d;
  logic          fire_prev_q, fire_prev_d;
  logic          hit_prev_q, hit_prev_d;
  logic          armed_q, armed_d;
  logic [1:0]    mem_q [DEPTH];

  logic          fire_edge, hit_edge;
  logic          fire_keep, hit_keep;
  logic          push_hit, push_fire, drop, pop;
  logic [AW:0]   free_slots;
  logic [AW-1:0] fire_idx;

  // armed_q masks the first clock after reset so a level held across release is not an edge.
  assign fire_edge = armed_q & fire_req & ~fire_prev_q;
  assign hit_edge  = armed_q & hit_req  & ~hit_prev_q;
  assign pop       = (state_q == S_ISSUE);

`ifdef SFX_COALESCE_EN
  logic [AW-1:0] newest_idx;
  logic          newest_hit, newest_fire;

  always_comb begin
    newest_idx  = wr_ptr_q - AW'(1);
    newest_hit  = (count_q != '0) && (mem_q[newest_idx] == CODE_HIT);
    newest_fire = (count_q != '0) && (mem_q[newest_idx] == CODE_FIRE);
    hit_keep    = hit_edge & ~newest_hit;
    // A kept hit becomes the newest entry, so the fire behind it is never a duplicate.
    fire_keep   = fire_edge & (hit_keep | ~newest_fire);
  end
`else
  assign hit_keep  = hit_edge;
  assign fire_keep = fire_edge;
`endif

  always_comb begin
    free_slots = FULL_CNT - count_q + (AW+1)'(pop);
    push_hit   = 1'b0;
    push_fire  = 1'b0;
    drop       = 1'b0;
    // Hit takes the first free slot; fire only gets one if another remains.
    if (hit_keep) begin
      if (free_slots != '0) push_hit = 1'b1;
      else                  drop     = 1'b1;
    end
    if (fire_keep) begin
      if (free_slots > (AW+1)'(push_hit)) push_fire = 1'b1;
      else                                drop      = 1'b1;
    end
    fire_idx    = wr_ptr_q + AW'(push_hit);
    wr_ptr_d    = wr_ptr_q + AW'(push_hit) + AW'(push_fire);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + (AW+1)'(push_hit) + (AW+1)'(push_fire) - (AW+1)'(pop);
    ovf_d       = clr_ovf ? 1'b0 : (ovf_q | drop);
    fire_prev_d = fire_req;
    hit_prev_d  = hit_req;
    armed_d     = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    play_d  = 1'b0;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_ISSUE;
          play_d  = 1'b1;
          code_d  = mem_q[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        state_d = S_ACK;
        cnt_d   = '0;
      end
      S_ACK: begin
        if (busy) begin
          state_d = S_PLAY;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PLAY: begin
        if (!busy) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage carries no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push_hit)  mem_q[wr_ptr_q] <= CODE_HIT;
    if (push_fire) mem_q[fire_idx] <= CODE_FIRE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      play_q      <= 1'b0;
      code_q      <= 2'b00;
      ovf_q       <= 1'b0;
      fire_prev_q <= 1'b0;
      hit_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      play_q      <= play_d;
      code_q      <= code_d;
      ovf_q       <= ovf_d;
      fire_prev_q <= fire_prev_d;
      hit_prev_q  <= hit_prev_d;
      armed_q     <= armed_d;
    end
  end

  assign play     = play_q;
  assign code     = code_q;
  assign pending  = count_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sfx_request_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sfx_request_queue : bench for sfx_request_queue with a queue-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sfx_request_queue;

  localparam int DEPTH  = 4;
  localparam int GAP    = 30;
  localparam int ACK_TO = 16;
  localparam int INF    = 32'h3fff_ffff;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       fire_req = 1'b0;
  logic       hit_req  = 1'b0;
  logic       busy     = 1'b0;
  logic       clr_ovf  = 1'b0;
  logic       play;
  logic [1:0] code;
  logic [2:0] pending;
  logic       overflow;

  sfx_request_queue #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .fire_req(fire_req),
    .hit_req (hit_req),
    .busy    (busy),
    .clr_ovf (clr_ovf),
    .play    (play),
    .code    (code),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Sound-player behaviour: busy rises cfg_a cycles after play for cfg_l cycles (cfg_a=0: never).
  bit rand_player = 1'b0;
  int cfg_a       = 0;
  int cfg_l       = 1;
  int busy_lo     = INF;
  int busy_hi     = -1;

  task automatic tick();
    @(posedge clk);
    #1;
    busy = (cyc >= busy_lo) && (cyc <= busy_hi);
  endtask

  // Reference model: queue contents plus the cycle at which the dispatcher is next free.
  int q[$];
  int m_code    = 0;
  int m_ovf     = 0;
  int issue_cyc = -1;
  int free_at   = 0;
  bit fprev     = 1'b0;
  bit hprev     = 1'b0;
  bit armed     = 1'b0;

  always @(negedge clk) begin : model
    bit pop, fe, he, drop, last_v;
    int sz, last, free, a, l;
    if (!reset) begin
      q.delete();
      m_code = 0; m_ovf = 0; issue_cyc = -1; free_at = 0;
      busy_lo = INF; busy_hi = -1;
      fprev = 1'b0; hprev = 1'b0; armed = 1'b0;
      chk("rst_play", play, 0);
      chk("rst_pending", pending, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_code", code, 0);
    end else begin
      pop = (cyc == issue_cyc);
      if (pop) m_code = q[0];
      sz = q.size();
      chk("play", play, pop);
      chk("code", code, m_code);
      chk("pending", pending, sz);
      chk("overflow", overflow, m_ovf);

      if (cyc >= free_at && sz > 0) begin
        issue_cyc = cyc + 1;
        free_at   = INF;
      end

      last_v = (sz > 0);
      last   = last_v ? q[$] : 0;
      if (pop) begin
        void'(q.pop_front());
        if (rand_player) begin
          a = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, ACK_TO);
          l = $urandom_range(1, 8);
        end else begin
          a = cfg_a;
          l = cfg_l;
        end
        if (a > 0) begin
          busy_lo = cyc + a;
          busy_hi = cyc + a + l - 1;
          free_at = cyc + a + l + GAP + 1;
        end else begin
          busy_lo = INF;
          busy_hi = -1;
          free_at = cyc + ACK_TO + GAP + 1;
        end
      end

      fe = armed && fire_req && !fprev;
      he = armed && hit_req && !hprev;
`ifdef SFX_COALESCE_EN
      if (he && last_v && last == 2) he = 1'b0;
      if (fe && !he && last_v && last == 1) fe = 1'b0;
`endif
      free = DEPTH - q.size();
      drop = 1'b0;
      if (he) begin
        if (free > 0) begin q.push_back(2); free--; end
        else drop = 1'b1;
      end
      if (fe) begin
        if (free > 0) q.push_back(1);
        else drop = 1'b1;
      end
      m_ovf = clr_ovf ? 0 : (m_ovf | int'(drop));
      fprev = fire_req;
      hprev = hit_req;
      armed = 1'b1;
    end
  end

  task automatic wait_play(input int lim, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int k = 0; k < lim && !seen; k++) begin
      if (play === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end else begin
        tick();
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL wait_play: no play within %0d cycles (cycle %0d)", lim, cyc);
    end
  endtask

  task automatic do_reset();
    tick();
    #2;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  int c0, tp, tp2, nplays, exp_cnt, prob;

  initial begin
    repeat (3) tick();
    chk("init_pending", pending, 0);
    chk("init_play", play, 0);
    chk("init_code", code, 0);
    chk("init_overflow", overflow, 0);
    reset = 1'b1;
    tick();

    // Single fire: latency 2, then busy for 50 cycles gates the next play.
    cfg_a = 1; cfg_l = 50;
    tick(); tick();
    fire_req = 1'b1; c0 = cyc; tick(); fire_req = 1'b0;
    wait_play(20, tp);
    chk("first_latency", tp - c0, 2);
    chk("first_code", code, 1);
    tick(); tick();
    fire_req = 1'b1; tick(); fire_req = 1'b0;
    wait_play(200, tp2);
    chk("busy_gap_spacing", tp2 - tp, 83);
    chk("second_code", code, 1);

    // Simultaneous edges, player never acknowledges.
    do_reset();
    cfg_a = 0;
    fire_req = 1'b1; hit_req = 1'b1; tick(); fire_req = 1'b0; hit_req = 1'b0;
    chk("both_pending", pending, 2);
    tick();
    chk("both_first_play", play, 1);
    chk("both_first_code", code, 2);
    tp = cyc;
    tick();
    wait_play(100, tp2);
    chk("timeout_spacing", tp2 - tp, 48);
    chk("both_second_code", code, 1);

    // Reset during the play cycle itself.
    do_reset();
    fire_req = 1'b1; tick(); fire_req = 1'b0;
    wait_play(20, tp);
    #1;
    reset = 1'b0;
    #1;
    chk("cutoff_play", play, 0);
    chk("cutoff_pending", pending, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Saturation, overflow and its clear; then reset mid-PLAY with the request held.
    do_reset();
    cfg_a = 1; cfg_l = 200;
    for (int i = 0; i < 6; i++) begin
      fire_req = 1'b1; tick(); fire_req = 1'b0; tick();
    end
    chk("sat_pending", pending, 4);
    chk("sat_overflow", overflow, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_pending", pending, 4);
    wait_play(300, tp);
    tick(); tick(); tick();
    chk("mid_play_pending", pending, 3);
    fire_req = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_play_rst_pending", pending, 0);
    chk("mid_play_rst_play", play, 0);
    tick(); tick();
    reset = 1'b1;
    nplays = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (play === 1'b1) nplays++;
    end
    chk("held_req_no_play", nplays, 0);
    chk("held_req_pending", pending, 0);
    fire_req = 1'b0;

    // Repeated fire edges while the player is busy.
    do_reset();
    cfg_a = 1; cfg_l = 100;
    fire_req = 1'b1; tick(); fire_req = 1'b0;
    wait_play(20, tp);
    tick();
    for (int i = 0; i < 3; i++) begin
      fire_req = 1'b1; tick(); fire_req = 1'b0; tick();
    end
`ifdef SFX_COALESCE_EN
    exp_cnt = 1;
`else
    exp_cnt = 3;
`endif
    chk("repeat_fire_pending", pending, exp_cnt);
    chk("repeat_fire_overflow", overflow, 0);

    // Randomised traffic.
    do_reset();
    rand_player = 1'b1;
    prob = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 800 == 0) prob = $urandom_range(1, 12);
      if ($urandom_range(0, prob) == 0) fire_req = ~fire_req;
      if ($urandom_range(0, prob) == 0) hit_req = ~hit_req;
      clr_ovf = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
      end
      tick();
    end
    fire_req = 1'b0; hit_req = 1'b0; clr_ovf = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
